xalu_nibble_sequencer: RTL and testbench
========================================

// Module: xalu_nibble_sequencer
// PURPOSE
//  Runs W-bit ALU operations (W = 4*NIBBLES) on one shared 4-bit ALU slice, one nibble per clock.
//  Latches operands on start, steps the slice nibble by nibble and chains carry/shift bits between cycles.
//  Accumulates the result and the EQU/ZERO flags, and adds an optional end-around-carry pass for 1's-complement ADD.
//  Sits between the register file/control unit and the ALU slice.
// PARAMETERS
//  NIBBLES  4  nibbles per operation; W = 4*NIBBLES, range 2..8
//  EAC_EN   1  1 = ADD with carry-out gets a second +1 pass (1's-complement end-around carry)
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  start     in   1  one-cycle request pulse; sampled only in IDLE
//  op        in   3  function: 0 ADD,1 AND,2 OR,3 XOR,4 PASSA,5 PASSB,6 SHR,7 SHL
//  com       in   1  1's-complement the final result
//  opa       in   W  operand A
//  opb       in   W  operand B
//  ci_in     in   1  carry-in (ADD), fill bit (SHL LSB, SHR MSB)
//  busy      out  1  high from the cycle after an accepted start until done
//  done      out  1  one-cycle pulse; result and flags are valid from this cycle
//  result    out  W  final result, held until the next accepted start
//  co_out    out  1  ADD/SHL: carry out of the MSB; SHR: bit shifted out of the LSB; otherwise 0
//  equ       out  1  opa == opb, full width
//  zero      out  1  result == 0
//  neg_zero  out  1  result == all ones
// BEHAVIOUR
//  Reset: state=IDLE. busy, done, result, co_out, equ, zero and neg_zero all reset to 0.
//  FSM: IDLE -> RUN -> (EAC) -> DONE -> IDLE.
//   IDLE: on start, latch op/com/opa/opb/ci_in, clear the nibble index, go to RUN.
//   RUN: one nibble per cycle for NIBBLES cycles.
//   EAC: entered only if EAC_EN=1, op=ADD and the final RUN carry is 1.
//   DONE: done=1 for one cycle, busy=0, then IDLE.
//  Latency: start in cycle 0 -> done in cycle NIBBLES+1, or 2*NIBBLES+1 when an EAC pass runs.
//   start is accepted again in the cycle after DONE.
//  Nibble order:
//   ADD, SHL, logic ops, PASS: LSB nibble first. Slice ci_right = ci_in on the first nibble,
//    then the previous cycle's co_left (registered).
//   SHR: MSB nibble first. Slice ci_left = ci_in on the first nibble,
//    then the previous cycle's co_right (registered).
//  Slice COM input is tied 0. The com inversion is applied once, to the full result, when DONE is entered.
//  EAC pass: op ADD, A = first-pass result, B = 0, initial ci_right = 1. Runs NIBBLES cycles.
//   Its carry-out is discarded. co_out reports the first-pass carry (1).
//  equ: AND of the per-nibble slice EQU outputs over the RUN pass only.
//  zero/neg_zero: computed from the final W-bit result after com is applied.
//  Boundaries:
//   start while busy or in DONE: ignored, no effect on latched operands.
//   Operand inputs changing after start: no effect.
//   rst_n asserted mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
//   ADD overflow wraps modulo 2^W (EAC_EN=0); co_out carries the lost bit.
// STRUCTURE
//  Shared package: op encodings (OP_ADD..OP_SHL), FSM state encodings, W = 4*NIBBLES.
//  One sub-module: xalu_slice4, the combinational 4-bit ALU slice, instanced once.
//  Controller owns: the FSM, the nibble index counter, the registered inter-nibble carry,
//   the W-bit result shift/assemble register and the equ accumulator.
// TESTING (NIBBLES=4, W=16)
//  EAC_EN=0, ADD 0x1234+0x0FFF, ci=0 -> result 0x2233, co_out 0, done exactly 5 cycles after start.
//  EAC_EN=1, ADD 0x8000+0x8000, ci=0 -> EAC pass runs; result 0x0001, co_out 1, done 9 cycles after start.
//  SHR 0x8001, ci=1 -> result 0xC000, co_out 1.
//  SHL 0x8001, ci=0 -> result 0x0002, co_out 1.
//  PASSA 0x0000, com=1 -> result 0xFFFF, neg_zero 1, zero 0.
//  XOR 0x5A5A^0x5A5A -> result 0x0000, zero 1, equ 1.
//  Second start pulsed while busy -> ignored.
//  rst_n pulsed in RUN cycle 2 -> IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/xalu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: op codes, FSM states, width helper.
package xalu_nibble_sequencer_pkg;

    localparam int DEFAULT_NIBBLES = 4;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_XOR   = 3'd3,
        OP_PASSA = 3'd4,
        OP_PASSB = 3'd5,
        OP_SHR   = 3'd6,
        OP_SHL   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EAC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Full operand width for a given nibble count.
    function automatic int word_width(input int nibbles);
        return 4 * nibbles;
    endfunction

endpackage

// File: rtl/xalu_slice4.sv
// Combinational 4-bit ALU slice; carries/shift bits leave on co_left (towards MSB) or co_right (towards LSB).
module xalu_slice4
    import xalu_nibble_sequencer_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  op_e        op,
    input  logic       com,
    input  logic       ci_right,
    input  logic       ci_left,
    output logic [3:0] f,
    output logic       co_left,
    output logic       co_right,
    output logic       equ
);

    logic [4:0] sum;
    logic [3:0] raw;

    // Evaluate the selected function on one nibble, then apply the optional inversion.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b} + {4'b0000, ci_right};
        raw      = a;
        co_left  = 1'b0;
        co_right = 1'b0;
        case (op)
            OP_ADD: begin
                raw     = sum[3:0];
                co_left = sum[4];
            end
            OP_AND:   raw = a & b;
            OP_OR:    raw = a | b;
            OP_XOR:   raw = a ^ b;
            OP_PASSA: raw = a;
            OP_PASSB: raw = b;
            OP_SHR: begin
                raw      = {ci_left, a[3:1]};
                co_right = a[0];
            end
            OP_SHL: begin
                raw     = {a[2:0], ci_right};
                co_left = a[3];
            end
            default: raw = a;
        endcase
        f   = com ? ~raw : raw;
        equ = (a == b);
    end

endmodule

// File: rtl/xalu_nibble_sequencer.sv
// Runs W-bit ALU operations through one shared 4-bit slice, one nibble per clock, with optional end-around carry.
module xalu_nibble_sequencer
    import xalu_nibble_sequencer_pkg::*;
#(
    parameter int NIBBLES = DEFAULT_NIBBLES,
    parameter bit EAC_EN  = 1'b1,
    localparam int W      = word_width(NIBBLES)
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         com,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic         ci_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         co_out,
    output logic         equ,
    output logic         zero,
    output logic         neg_zero
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e        state, state_next;
    op_e           op_q;
    logic          com_q, ci_q;
    logic [W-1:0]  a_q, b_q, work, work_next, final_val;
    logic [IW-1:0] idx, pos;
    logic          last, carry_q, first_co, equ_acc, equ_next, run_co, chain, eac_take;
    logic [3:0]    s_a, s_b, s_f;
    op_e           s_op;
    logic          s_cir, s_cil, s_col, s_cor, s_equ;

    xalu_slice4 u_slice (
        .a        (s_a),
        .b        (s_b),
        .op       (s_op),
        .com      (1'b0),
        .ci_right (s_cir),
        .ci_left  (s_cil),
        .f        (s_f),
        .co_left  (s_col),
        .co_right (s_cor),
        .equ      (s_equ)
    );

    // Select the nibble to process this cycle and assemble the next working value and chained bits.
    always_comb begin
        last      = (idx == IW'(NIBBLES - 1));
        pos       = (state == ST_RUN && op_q == OP_SHR) ? (IW'(NIBBLES - 1) - idx) : idx;
        s_op      = (state == ST_EAC) ? OP_ADD : op_q;
        s_a       = (state == ST_EAC) ? work[{pos, 2'b00} +: 4] : a_q[{pos, 2'b00} +: 4];
        s_b       = (state == ST_EAC) ? 4'h0 : b_q[{pos, 2'b00} +: 4];
        s_cir     = (idx == '0) ? ((state == ST_EAC) ? 1'b1 : ci_q) : carry_q;
        s_cil     = (idx == '0) ? ci_q : carry_q;
        work_next = work;
        work_next[{pos, 2'b00} +: 4] = s_f;
        run_co    = (op_q == OP_SHR) ? s_cor : s_col;
        chain     = (s_op == OP_SHR) ? s_cor : s_col;
        eac_take  = EAC_EN && (op_q == OP_ADD) && s_col;
        equ_next  = (state == ST_RUN) ? (equ_acc & s_equ) : equ_acc;
        final_val = com_q ? ~work_next : work_next;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next-state: one RUN pass, an optional end-around-carry pass, then a single DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = eac_take ? ST_EAC : ST_DONE;
            ST_EAC:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: busy while stepping nibbles, done for the single DONE cycle.
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_EAC);
        done = (state == ST_DONE);
    end

    // Operand latch, nibble counter, inter-nibble carry, working register and result/flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            com_q    <= 1'b0;
            ci_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            carry_q  <= 1'b0;
            work     <= '0;
            equ_acc  <= 1'b0;
            first_co <= 1'b0;
            result   <= '0;
            co_out   <= 1'b0;
            equ      <= 1'b0;
            zero     <= 1'b0;
            neg_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        com_q   <= com;
                        ci_q    <= ci_in;
                        a_q     <= opa;
                        b_q     <= opb;
                        idx     <= '0;
                        carry_q <= 1'b0;
                        equ_acc <= 1'b1;
                    end
                end
                ST_RUN, ST_EAC: begin
                    work    <= work_next;
                    carry_q <= chain;
                    idx     <= last ? '0 : idx + 1'b1;
                    if (state == ST_RUN) begin
                        equ_acc <= equ_next;
                        if (last) first_co <= run_co;
                    end
                    if (state_next == ST_DONE) begin
                        result   <= final_val;
                        zero     <= (final_val == '0);
                        neg_zero <= &final_val;
                        equ      <= equ_next;
                        co_out   <= (state == ST_RUN) ? run_co : first_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// Directed self-checking bench for xalu_nibble_sequencer, with and without end-around carry.
module tb_xalu_nibble_sequencer;

    localparam int W = 16;

    localparam logic [2:0] ADD   = 3'd0;
    localparam logic [2:0] AND_  = 3'd1;
    localparam logic [2:0] OR_   = 3'd2;
    localparam logic [2:0] XOR_  = 3'd3;
    localparam logic [2:0] PASSA = 3'd4;
    localparam logic [2:0] SHR   = 3'd6;
    localparam logic [2:0] SHL   = 3'd7;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic         com   = 1'b0;
    logic [W-1:0] opa   = '0;
    logic [W-1:0] opb   = '0;
    logic         ci_in = 1'b0;

    logic         busy1, done1, co1, equ1, zero1, nz1;
    logic [W-1:0] result1;
    logic         busy0, done0, co0, equ0, zero0, nz0;
    logic [W-1:0] result0;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int doneCount = 0;
    int dcSnap    = 0;

    xalu_nibble_sequencer #(.NIBBLES(4), .EAC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com),
        .opa(opa), .opb(opb), .ci_in(ci_in),
        .busy(busy1), .done(done1), .result(result1), .co_out(co1),
        .equ(equ1), .zero(zero1), .neg_zero(nz1)
    );

    xalu_nibble_sequencer #(.NIBBLES(4), .EAC_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com),
        .opa(opa), .opb(opb), .ci_in(ci_in),
        .busy(busy0), .done(done0), .result(result0), .co_out(co0),
        .equ(equ0), .zero(zero0), .neg_zero(nz0)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count every done pulse seen on either instance.
    always @(negedge clk) if (done1 || done0) doneCount++;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        cyc++;
    endtask

    // Drive one request in cycle 0; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [2:0] o, input logic c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        op = o; com = c; opa = a; opb = b; ci_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic waitDone(input bit sel, input string tag);
        while (!(sel ? done1 : done0) && cyc < 40) stepCycle();
        checkOutput(tag, {31'd0, (sel ? done1 : done0)}, 32'd1);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((busy1 || busy0 || done1 || done0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_reached", {30'd0, busy1, busy0}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",   {31'd0, busy1},   32'd0);
        checkOutput("rst_done",   {31'd0, done1},   32'd0);
        checkOutput("rst_result", {16'd0, result1}, 32'd0);
        checkOutput("rst_flags",  {27'd0, co1, equ1, zero1, nz1, zero0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 0x1234 + 0x0FFF on EAC_EN=0, latency 5
        applyStimulus(ADD, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
        checkOutput("add_busy_c1", {31'd0, busy0}, 32'd1);
        waitDone(1'b0, "add_done");
        checkOutput("add_latency", cyc,               32'd5);
        checkOutput("add_result",  {16'd0, result0},  32'h2233);
        checkOutput("add_co",      {31'd0, co0},      32'd0);
        checkOutput("add_equ",     {31'd0, equ0},     32'd0);
        checkOutput("add_busy_dn", {31'd0, busy0},    32'd0);
        checkOutput("add_eac_res", {16'd0, result1},  32'h2233);
        @(negedge clk);
        checkOutput("add_done_pulse", {31'd0, done0}, 32'd0);
        waitIdle();

        // ADD 0x8000 + 0x8000: wraps on EAC_EN=0, end-around carry on EAC_EN=1
        applyStimulus(ADD, 1'b0, 16'h8000, 16'h8000, 1'b0);
        waitDone(1'b0, "ovf_done0");
        checkOutput("ovf_lat0",    cyc,              32'd5);
        checkOutput("ovf_res0",    {16'd0, result0}, 32'h0000);
        checkOutput("ovf_co0",     {31'd0, co0},     32'd1);
        checkOutput("ovf_zero0",   {31'd0, zero0},   32'd1);
        checkOutput("eac_busy",    {31'd0, busy1},   32'd1);
        waitDone(1'b1, "eac_done");
        checkOutput("eac_latency", cyc,              32'd9);
        checkOutput("eac_result",  {16'd0, result1}, 32'h0001);
        checkOutput("eac_co",      {31'd0, co1},     32'd1);
        checkOutput("eac_equ",     {31'd0, equ1},    32'd1);
        checkOutput("eac_zero",    {31'd0, zero1},   32'd0);
        waitIdle();

        // SHR 0x8001, fill 1
        applyStimulus(SHR, 1'b0, 16'h8001, 16'h0000, 1'b1);
        waitDone(1'b1, "shr_done");
        checkOutput("shr_latency", cyc,              32'd5);
        checkOutput("shr_result",  {16'd0, result1}, 32'hC000);
        checkOutput("shr_co",      {31'd0, co1},     32'd1);
        waitIdle();

        // SHL 0x8001, fill 0
        applyStimulus(SHL, 1'b0, 16'h8001, 16'h0000, 1'b0);
        waitDone(1'b1, "shl_done");
        checkOutput("shl_result",  {16'd0, result1}, 32'h0002);
        checkOutput("shl_co",      {31'd0, co1},     32'd1);
        waitIdle();

        // PASSA 0x0000 with complement
        applyStimulus(PASSA, 1'b1, 16'h0000, 16'h1111, 1'b0);
        waitDone(1'b1, "pass_done");
        checkOutput("pass_result", {16'd0, result1}, 32'hFFFF);
        checkOutput("pass_negz",   {31'd0, nz1},     32'd1);
        checkOutput("pass_zero",   {31'd0, zero1},   32'd0);
        checkOutput("pass_co",     {31'd0, co1},     32'd0);
        waitIdle();

        // XOR of equal operands
        applyStimulus(XOR_, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0);
        waitDone(1'b1, "xor_done");
        checkOutput("xor_result",  {16'd0, result1}, 32'h0000);
        checkOutput("xor_zero",    {31'd0, zero1},   32'd1);
        checkOutput("xor_equ",     {31'd0, equ1},    32'd1);
        checkOutput("xor_negz",    {31'd0, nz1},     32'd0);
        waitIdle();

        // Second start while busy, operands changing after start, start during DONE
        applyStimulus(ADD, 1'b0, 16'h0001, 16'h0002, 1'b0);
        op = OR_; opa = 16'hFFFF; opb = 16'hFFFF; ci_in = 1'b1; start = 1'b1;
        stepCycle();
        start = 1'b0;
        waitDone(1'b1, "ign_done");
        checkOutput("ign_latency", cyc,              32'd5);
        checkOutput("ign_result",  {16'd0, result1}, 32'h0003);
        checkOutput("ign_co",      {31'd0, co1},     32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ign_dn_busy1", {30'd0, busy1, done1}, 32'd0);
        @(negedge clk);
        checkOutput("ign_dn_busy2", {30'd0, busy1, busy0}, 32'd0);

        // Reset asserted in RUN cycle 2
        applyStimulus(ADD, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        stepCycle();
        dcSnap = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",   {30'd0, busy1, done1}, 32'd0);
        checkOutput("mid_rst_result", {16'd0, result1},      32'd0);
        checkOutput("mid_rst_res0",   {16'd0, result0},      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("mid_rst_nodone", doneCount,             dcSnap);
        checkOutput("mid_rst_idle",   {30'd0, busy1, busy0}, 32'd0);
        checkOutput("mid_rst_flags",  {27'd0, co1, equ1, zero1, nz1, zero0}, 32'd0);

        // Recovery after reset: AND
        applyStimulus(AND_, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
        waitDone(1'b1, "and_done");
        checkOutput("and_latency", cyc,              32'd5);
        checkOutput("and_result",  {16'd0, result1}, 32'h3030);
        checkOutput("and_co",      {31'd0, co1},     32'd0);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
